// File: rtl/linescanner_capture_sequencer.sv
// linescanner_capture_sequencer
// Line-scan sensor front end. Three independent blocks share one clock:
//   - exposure FSM: times the rst_cvc / rst_cds / sample sequence, either
//     back-to-back (continuous mode) or once per trigger (single-shot mode)
//   - load FSM: after end_adc it waits for the line to finish, leaves a gap
//     and then issues load_pulse, firing once per end_adc assertion
//   - capture path: registers lval-framed pixels with index, line markers
//     and a line-length check
// Ports:
//   pixel_clock, n_reset (async, active-low)
//   enable, single_shot, trigger        exposure control
//   data, lval, end_adc                 sensor inputs
//   rst_cvc, rst_cds, sample, load_pulse sensor controls (all registered)
//   pixel_data, pixel_valid, pixel_index, line_start, line_end,
//   line_len_err                        captured pixel stream
//   seq_busy                            exposure in progress
//   dbg_seq_state, dbg_load_state       current FSM states
// The pixel stream is valid-only: a pixel is transferred on every cycle
// pixel_valid is high, with no backpressure, so downstream must always
// accept it.
module linescanner_capture_sequencer #(
  parameter int DATA_W   = 8,
  parameter int PIXELS   = 1024,
  parameter int T_CVC    = 48,
  parameter int T_CDS    = 7,
  parameter int T_SAMPLE = 48,
  parameter int T_HOLD   = 6,
  parameter int LOAD_GAP = 3,
  parameter int LOAD_W   = 1
) (
  input  logic                       pixel_clock,
  input  logic                       n_reset,
  input  logic                       enable,
  input  logic                       single_shot,
  input  logic                       trigger,
  input  logic [DATA_W-1:0]          data,
  input  logic                       lval,
  input  logic                       end_adc,
  output logic                       rst_cvc,
  output logic                       rst_cds,
  output logic                       sample,
  output logic                       load_pulse,
  output logic [DATA_W-1:0]          pixel_data,
  output logic                       pixel_valid,
  output logic [$clog2(PIXELS)-1:0]  pixel_index,
  output logic                       line_start,
  output logic                       line_end,
  output logic                       line_len_err,
  output logic                       seq_busy,
  output logic [2:0]                 dbg_seq_state,
  output logic [2:0]                 dbg_load_state
);

  localparam int T_MAX_A = (T_CVC > T_CDS) ? T_CVC : T_CDS;
  localparam int T_MAX_B = (T_SAMPLE > T_HOLD) ? T_SAMPLE : T_HOLD;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int SEQ_CW  = $clog2(T_MAX + 1);
  localparam int LD_MAX  = (LOAD_GAP > LOAD_W) ? LOAD_GAP : LOAD_W;
  localparam int LD_CW   = $clog2(LD_MAX + 1);
  localparam int IDX_W   = $clog2(PIXELS);
  localparam int CNT_W   = $clog2(PIXELS + 1);

  localparam logic [2:0] SEQ_IDLE = 3'd0;
  localparam logic [2:0] SEQ_CVC  = 3'd1;
  localparam logic [2:0] SEQ_CDS  = 3'd2;
  localparam logic [2:0] SEQ_SMP  = 3'd3;
  localparam logic [2:0] SEQ_HOLD = 3'd4;

  localparam logic [2:0] L_WAIT_EOC     = 3'd0;
  localparam logic [2:0] L_WAIT_LVAL    = 3'd1;
  localparam logic [2:0] L_GAP          = 3'd2;
  localparam logic [2:0] L_PULSE        = 3'd3;
  localparam logic [2:0] L_WAIT_EOC_LOW = 3'd4;

  // ---------------- exposure FSM ----------------
  logic [2:0]        seq_q, seq_d;
  logic [SEQ_CW-1:0] scnt_q, scnt_d;
  logic              seq_zero;

  assign seq_zero = (scnt_q == '0);

  // Each timed state loads the shared counter with its length minus one on
  // entry and leaves when the counter reaches zero.
  always_comb begin
    seq_d  = seq_q;
    scnt_d = scnt_q;
    case (seq_q)
      SEQ_IDLE: begin
        if ((!single_shot && enable) || (single_shot && trigger)) begin
          seq_d  = SEQ_CVC;
          scnt_d = SEQ_CW'(T_CVC - 1);
        end
      end
      SEQ_CVC: begin
        if (seq_zero) begin
          seq_d  = SEQ_CDS;
          scnt_d = SEQ_CW'(T_CDS - 1);
        end else begin
          scnt_d = scnt_q - SEQ_CW'(1);
        end
      end
      SEQ_CDS: begin
        if (seq_zero) begin
          seq_d  = SEQ_SMP;
          scnt_d = SEQ_CW'(T_SAMPLE - 1);
        end else begin
          scnt_d = scnt_q - SEQ_CW'(1);
        end
      end
      SEQ_SMP: begin
        if (seq_zero) begin
          seq_d  = SEQ_HOLD;
          scnt_d = SEQ_CW'(T_HOLD - 1);
        end else begin
          scnt_d = scnt_q - SEQ_CW'(1);
        end
      end
      SEQ_HOLD: begin
        if (seq_zero) begin
          seq_d = SEQ_IDLE;
        end else begin
          scnt_d = scnt_q - SEQ_CW'(1);
        end
      end
      default: seq_d = SEQ_IDLE;
    endcase
  end

  // Sensor controls are decoded from the next state so they change on the
  // same edge as the state transition and come straight from flops.
  always_ff @(posedge pixel_clock or negedge n_reset) begin
    if (!n_reset) begin
      seq_q    <= SEQ_IDLE;
      scnt_q   <= '0;
      rst_cvc  <= 1'b1;
      rst_cds  <= 1'b1;
      sample   <= 1'b0;
      seq_busy <= 1'b0;
    end else begin
      seq_q    <= seq_d;
      scnt_q   <= scnt_d;
      rst_cvc  <= (seq_d == SEQ_IDLE);
      rst_cds  <= !((seq_d == SEQ_CDS) || (seq_d == SEQ_SMP) || (seq_d == SEQ_HOLD));
      sample   <= (seq_d == SEQ_SMP);
      seq_busy <= (seq_d != SEQ_IDLE);
    end
  end

  // ---------------- load FSM ----------------
  logic [2:0]       ld_q, ld_d;
  logic [LD_CW-1:0] lcnt_q, lcnt_d;
  logic [2:0]       gap_state;
  logic [LD_CW-1:0] gap_cnt;

  // With a zero gap the pulse starts directly.
  assign gap_state = (LOAD_GAP == 0) ? L_PULSE : L_GAP;
  assign gap_cnt   = (LOAD_GAP == 0) ? LD_CW'(LOAD_W - 1) : LD_CW'(LOAD_GAP - 1);

  always_comb begin
    ld_d   = ld_q;
    lcnt_d = lcnt_q;
    case (ld_q)
      L_WAIT_EOC: begin
        if (end_adc) begin
          if (lval) begin
            ld_d = L_WAIT_LVAL;
          end else begin
            ld_d   = gap_state;
            lcnt_d = gap_cnt;
          end
        end
      end
      L_WAIT_LVAL: begin
        if (!lval) begin
          ld_d   = gap_state;
          lcnt_d = gap_cnt;
        end
      end
      L_GAP: begin
        if (lcnt_q == '0) begin
          ld_d   = L_PULSE;
          lcnt_d = LD_CW'(LOAD_W - 1);
        end else begin
          lcnt_d = lcnt_q - LD_CW'(1);
        end
      end
      L_PULSE: begin
        if (lcnt_q == '0) begin
          ld_d = L_WAIT_EOC_LOW;
        end else begin
          lcnt_d = lcnt_q - LD_CW'(1);
        end
      end
      // end_adc must drop before another load can be armed.
      L_WAIT_EOC_LOW: begin
        if (!end_adc) ld_d = L_WAIT_EOC;
      end
      default: ld_d = L_WAIT_EOC;
    endcase
  end

  always_ff @(posedge pixel_clock or negedge n_reset) begin
    if (!n_reset) begin
      ld_q       <= L_WAIT_EOC;
      lcnt_q     <= '0;
      load_pulse <= 1'b0;
    end else begin
      ld_q       <= ld_d;
      lcnt_q     <= lcnt_d;
      load_pulse <= (ld_d == L_PULSE);
    end
  end

  // ---------------- capture path ----------------
  logic              lval_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] pdata_d;
  logic [IDX_W-1:0]  pidx_d;
  logic              pv_d, ls_d, le_d, err_d;

  // cnt_q counts accepted pixels and saturates at PIXELS; ovf_q remembers
  // that further pixels were dropped, since a saturated count alone would
  // look like a correct line.
  always_comb begin
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    pdata_d = pixel_data;
    pidx_d  = pixel_index;
    pv_d    = 1'b0;
    ls_d    = 1'b0;
    le_d    = 1'b0;
    err_d   = 1'b0;
    if (lval) begin
      if (!lval_q) begin
        cnt_d   = CNT_W'(1);
        ovf_d   = 1'b0;
        pv_d    = 1'b1;
        pidx_d  = '0;
        pdata_d = data;
        ls_d    = 1'b1;
      end else if (cnt_q < CNT_W'(PIXELS)) begin
        cnt_d   = cnt_q + CNT_W'(1);
        pv_d    = 1'b1;
        pidx_d  = IDX_W'(cnt_q);
        pdata_d = data;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (lval_q) begin
      le_d  = 1'b1;
      err_d = ovf_q || (cnt_q != CNT_W'(PIXELS));
    end
  end

  always_ff @(posedge pixel_clock or negedge n_reset) begin
    if (!n_reset) begin
      lval_q       <= 1'b0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      pixel_data   <= '0;
      pixel_index  <= '0;
      pixel_valid  <= 1'b0;
      line_start   <= 1'b0;
      line_end     <= 1'b0;
      line_len_err <= 1'b0;
    end else begin
      lval_q       <= lval;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      pixel_data   <= pdata_d;
      pixel_index  <= pidx_d;
      pixel_valid  <= pv_d;
      line_start   <= ls_d;
      line_end     <= le_d;
      line_len_err <= err_d;
    end
  end

  assign dbg_seq_state  = seq_q;
  assign dbg_load_state = ld_q;

endmodule

// File: tb/tb_linescanner_capture_sequencer.sv
// Directed bench for linescanner_capture_sequencer (PIXELS=8, default timing).
module tb_linescanner_capture_sequencer;

  localparam int DATA_W = 8;
  localparam int PIXELS = 8;

  // ---------------- clock / reset ----------------
  logic pixel_clock = 1'b0;
  logic n_reset     = 1'b0;
  always #5 pixel_clock = ~pixel_clock;

  logic              enable      = 1'b0;
  logic              single_shot = 1'b0;
  logic              trigger     = 1'b0;
  logic [DATA_W-1:0] data        = '0;
  logic              lval        = 1'b0;
  logic              end_adc     = 1'b0;
  logic              rst_cvc, rst_cds, sample, load_pulse;
  logic [DATA_W-1:0] pixel_data;
  logic              pixel_valid;
  logic [2:0]        pixel_index;
  logic              line_start, line_end, line_len_err, seq_busy;
  logic [2:0]        dbg_seq_state, dbg_load_state;

  linescanner_capture_sequencer #(
    .DATA_W(DATA_W),
    .PIXELS(PIXELS)
  ) dut (
    .pixel_clock   (pixel_clock),
    .n_reset       (n_reset),
    .enable        (enable),
    .single_shot   (single_shot),
    .trigger       (trigger),
    .data          (data),
    .lval          (lval),
    .end_adc       (end_adc),
    .rst_cvc       (rst_cvc),
    .rst_cds       (rst_cds),
    .sample        (sample),
    .load_pulse    (load_pulse),
    .pixel_data    (pixel_data),
    .pixel_valid   (pixel_valid),
    .pixel_index   (pixel_index),
    .line_start    (line_start),
    .line_end      (line_end),
    .line_len_err  (line_len_err),
    .seq_busy      (seq_busy),
    .dbg_seq_state (dbg_seq_state),
    .dbg_load_state(dbg_load_state)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every valid pixel must match the head of the expected queue;
  // an unexpected pixel is compared against an impossible value.
  always @(negedge pixel_clock) begin
    if (n_reset && pixel_valid) begin
      logic [15:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
      check("pixel_idx_data", {21'd0, pixel_index, pixel_data}, {16'd0, e});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge pixel_clock);
  endtask

  task automatic push_pix(input int idx, input logic [7:0] d);
    exp_q.push_back({5'd0, 3'(idx), d});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // reset state
    step(1);
    check("reset_ctrl", {rst_cvc, rst_cds, sample, load_pulse, seq_busy}, 5'b11000);
    check("reset_pix",  {pixel_valid, line_start, line_end, line_len_err}, 4'b0000);
    check("reset_data", {pixel_index, pixel_data}, 11'd0);
    n_reset = 1'b1;
    step(1);

    // continuous mode: exit IDLE on the first edge with enable high
    enable = 1'b1;
    step(1);                                        // c=1
    check("cont_cvc_fall", {rst_cvc, rst_cds, seq_busy}, 3'b011);
    step(47);                                       // c=48
    check("cont_cds_before", {rst_cds, sample}, 2'b10);
    step(1);                                        // c=49
    check("cont_cds_fall", rst_cds, 1'b0);
    step(6);                                        // c=55
    check("cont_smp_before", sample, 1'b0);
    step(1);                                        // c=56
    check("cont_smp_rise", sample, 1'b1);
    step(47);                                       // c=103
    check("cont_smp_last", sample, 1'b1);
    step(1);                                        // c=104
    check("cont_smp_fall", {sample, rst_cvc, rst_cds}, 3'b000);
    step(5);                                        // c=109
    check("cont_hold_last", rst_cvc, 1'b0);
    step(1);                                        // c=110
    check("cont_release", {rst_cvc, rst_cds, seq_busy}, 3'b110);
    step(1);                                        // c=111
    check("cont_restart", {rst_cvc, seq_busy}, 2'b01);
    enable = 1'b0;
    step(39);                                       // c=150
    check("cont_no_abort", seq_busy, 1'b1);
    step(70);                                       // c=220
    check("cont_done", {rst_cvc, seq_busy}, 2'b10);
    step(5);
    check("cont_stays_idle", seq_busy, 1'b0);

    // single-shot: enable is ignored, retrigger while busy is ignored
    single_shot = 1'b1;
    enable      = 1'b1;
    step(3);
    check("ss_wait_trigger", seq_busy, 1'b0);
    trigger = 1'b1;
    step(1);                                        // c=1
    trigger = 1'b0;
    check("ss_start", {rst_cvc, seq_busy}, 2'b01);
    step(19);                                       // c=20
    trigger = 1'b1;
    step(1);                                        // c=21
    trigger = 1'b0;
    step(88);                                       // c=109
    check("ss_busy_end", seq_busy, 1'b1);
    step(1);                                        // c=110
    check("ss_done", {rst_cvc, rst_cds, seq_busy}, 3'b110);
    step(20);
    check("ss_one_only", {rst_cvc, seq_busy}, 2'b10);

    // async reset while sampling
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    step(59);                                       // c=60, in SMP
    check("rst_pre_smp", {sample, rst_cvc, rst_cds}, 3'b100);
    n_reset = 1'b0;
    #1;
    check("rst_async", {sample, rst_cvc, rst_cds, seq_busy}, 4'b0110);
    step(1);
    check("rst_held", {sample, rst_cvc, rst_cds}, 3'b011);
    n_reset = 1'b1;
    step(1);
    check("rst_no_resume", {sample, seq_busy}, 2'b00);
    trigger = 1'b1;
    step(1);                                        // c=1
    trigger = 1'b0;
    check("rst_restart", rst_cvc, 1'b0);
    step(54);                                       // c=55
    check("rst_smp_before", sample, 1'b0);
    step(1);                                        // c=56
    check("rst_smp_rise", {sample, rst_cds}, 2'b10);
    step(54);                                       // c=110
    check("rst_seq_done", seq_busy, 1'b0);
    enable      = 1'b0;
    single_shot = 1'b0;

    // capture: exactly PIXELS pixels
    for (int i = 0; i < 8; i++) begin
      lval = 1'b1;
      data = 8'h10 + 8'(i);
      push_pix(i, data);
      step(1);
      if (i == 0) check("cap_line_start", line_start, 1'b1);
      if (i == 1) check("cap_start_once", line_start, 1'b0);
    end
    lval = 1'b0;
    data = '0;
    step(1);
    check("cap_line_end", {line_end, line_len_err}, 2'b10);
    step(1);
    check("cap_end_pulse", {line_end, pixel_valid}, 2'b00);
    check("cap_all_seen", exp_q.size(), 0);

    // overlong line with end_adc rising alongside lval: load waits for lval low
    end_adc = 1'b1;
    for (int i = 0; i < 10; i++) begin
      lval = 1'b1;
      data = 8'h20 + 8'(i);
      if (i < 8) push_pix(i, data);
      step(1);
    end
    check("ld_wait_lval", load_pulse, 1'b0);
    lval = 1'b0;
    data = '0;
    step(1);                                        // GAP entry
    check("ovf_line_end", {line_end, line_len_err, load_pulse}, 3'b110);
    step(2);
    check("ld_gap", load_pulse, 1'b0);
    step(1);
    check("ld_pulse", load_pulse, 1'b1);
    step(1);
    check("ld_pulse_width", load_pulse, 1'b0);
    for (int i = 0; i < 45; i++) begin
      step(1);
      check("ld_no_retrigger", load_pulse, 1'b0);
    end
    check("ovf_all_seen", exp_q.size(), 0);
    end_adc = 1'b0;
    step(2);

    // re-armed, lval already low: WAIT_LVAL skipped
    end_adc = 1'b1;
    step(3);
    check("ld2_gap", load_pulse, 1'b0);
    step(1);
    check("ld2_pulse", load_pulse, 1'b1);
    end_adc = 1'b0;
    step(1);
    check("ld2_pulse_end", load_pulse, 1'b0);

    // single-cycle line
    lval = 1'b1;
    data = 8'hA5;
    push_pix(0, data);
    step(1);
    check("short_start", line_start, 1'b1);
    lval = 1'b0;
    step(1);
    check("short_end_err", {line_end, line_len_err}, 2'b11);
    step(2);
    check("short_all_seen", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
